// File: rtl/fdct_zigzag_reorder_buf_if.sv
// Coefficient stream bundle for fdct_zigzag_reorder_buf: row-major input side, zigzag output side.
// dout_sob exists only when ZZ_SOB_EN is defined.
interface fdct_zigzag_reorder_buf_if #(
    parameter int DW = 12
);
    // Valid/ready: a word moves on a rising edge where valid & ready; valid never waits on ready.
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout;
`ifdef ZZ_SOB_EN
    logic          dout_sob;

    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout, dout_sob
    );
    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout, dout_sob
    );
`else
    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout
    );
    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout
    );
`endif
endinterface

// File: rtl/fdct_zigzag_reorder_buf.sv
// Ping-pong 2x64 coefficient buffer: fills row-major, drains in JPEG zigzag order.
// Optional start-of-block marker on dout_sob when ZZ_SOB_EN is defined.
module fdct_zigzag_reorder_buf #(
    parameter int DW   = 12,
    parameter int NBLK = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    fdct_zigzag_reorder_buf_if.slave       bus
);
    if (NBLK != 64) begin : g_nblk_chk
        $error("fdct_zigzag_reorder_buf: NBLK must be 64");
    end

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DW-1:0] mem [128];
    logic [1:0]    full, full_nxt;
    logic          wr_bank, rd_bank;
    logic [5:0]    wr_idx, rd_idx;
    logic [DW-1:0] dout_hold;
    logic [DW-1:0] rd_data;
    logic          din_ready_i, dout_valid_i;
    logic          wr_fire, rd_fire;

    assign din_ready_i  = ~rst & ena & ~full[wr_bank];
    assign dout_valid_i = ~rst & ena & full[rd_bank];
    assign wr_fire      = bus.din_valid & din_ready_i;
    assign rd_fire      = dout_valid_i & bus.dout_ready;
    assign rd_data      = mem[{rd_bank, ZZ[rd_idx]}];

    assign bus.din_ready  = din_ready_i;
    assign bus.dout_valid = dout_valid_i;
    // When nothing is presented the last shown coefficient is replayed, so dout is never X.
    assign bus.dout       = dout_valid_i ? rd_data : dout_hold;

`ifdef ZZ_SOB_EN
    assign bus.dout_sob   = dout_valid_i & (rd_idx == 6'd0);
`endif

    // Write and read never touch the same bank's flag: a bank is written only while empty, read only while full.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_idx == 6'd63) full_nxt[wr_bank] = 1'b1;
        if (rd_fire && rd_idx == 6'd63) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= 6'd0;
            rd_idx    <= 6'd0;
            dout_hold <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_idx <= wr_idx + 6'd1;
                if (wr_idx == 6'd63) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + 6'd1;
                if (rd_idx == 6'd63) rd_bank <= ~rd_bank;
            end
            if (dout_valid_i) dout_hold <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_idx}] <= bus.din;
    end
endmodule
